// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit,
// then the stop period. Every bit lasts 16 s_ticks from the baud generator.
// The tx pin is driven from a register that is loaded from the next-state
// line level, so tx moves on the same edge as the state.
module uart_tx #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16,  // s_ticks in stop: 16 = 1, 24 = 1.5, 32 = 2 stop bits
    parameter int PARITY  = 0    // 0 = none, 1 = even, 2 = odd
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic [4:0] S_BIT_LAST  = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);
    localparam logic       PAR_EN      = (PARITY != 0);
    // Odd parity starts the running XOR at 1 so the final value makes the
    // total count of ones odd; even parity starts at 0.
    localparam logic       PAR_INIT    = (PARITY == 2);

    logic [2:0] state_reg, state_next;
    logic [4:0] s_reg, s_next;
    logic [2:0] n_reg, n_next;
    logic [7:0] b_reg, b_next;
    logic       par_reg, par_next;
    logic       tx_reg, tx_next;

    // Line level that a given state puts on the pin.
    function automatic logic line_level(input logic [2:0] st,
                                        input logic       b0,
                                        input logic       par);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = b0;
            ST_PAR:   lvl = par;
            default:  lvl = 1'b1;   // idle and stop are both mark level
        endcase
        return lvl;
    endfunction

    // State, counters, shift register, parity and the registered tx level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= 5'd0;
            n_reg     <= 3'd0;
            b_reg     <= 8'd0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
        end
    end

    // Next-state logic; counters only advance on s_tick, so an s_tick in the
    // acceptance cycle is dropped because idle does not look at it.
    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        par_next     = par_reg;
        tx_done_tick = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tx_start) begin
                    b_next     = din;
                    par_next   = PAR_INIT;
                    s_next     = 5'd0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = 5'd0;
                        n_next     = 3'd0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next   = 5'd0;
                        b_next   = b_reg >> 1;
                        par_next = par_reg ^ b_reg[0];
                        if (n_reg == N_LAST) begin
                            state_next = PAR_EN ? ST_PAR : ST_STOP;
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_PAR: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_LAST) begin
                        s_next     = 5'd0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP_LAST) begin
                        s_next       = 5'd0;
                        tx_done_tick = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        tx_next = line_level(state_next, b_next[0], par_next);
    end

    assign tx_busy = (state_reg != ST_IDLE);
    assign tx      = tx_reg;

endmodule
